// File: rtl/ysyx_22040000_pipe_buf.sv
// Two-entry in-order skid buffer: registers every valid/ready path so neither
// side sees a combinational path to the other.
module ysyx_22040000_pipe_buf #(
  parameter int           N    = 32,
  parameter logic [N-1:0] INIT = {N{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [N-1:0] r_head;
  logic [N-1:0] r_tail;
  logic         w_push;
  logic         w_pop;

  assign w_push = in_valid && r_in_ready;
  assign w_pop  = r_out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_push) w_state_nxt = ONE;
      ONE: begin
        if (w_push && !w_pop)      w_state_nxt = FULL;
        else if (!w_push && w_pop) w_state_nxt = EMPTY;
      end
      FULL:  if (w_pop) w_state_nxt = ONE;
      default: w_state_nxt = EMPTY;
    endcase
    if (flush) w_state_nxt = EMPTY;
  end

  // Handshake flags are precomputed from the next state so they leave flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != FULL);
      r_out_valid <= (w_state_nxt != EMPTY);
    end
  end

  // Head always holds the oldest entry; flush only drops validity, not data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= INIT;
      r_tail <= INIT;
    end else if (!flush) begin
      case (r_state)
        EMPTY: if (w_push) r_head <= in_data;
        ONE: begin
          if (w_push && w_pop) r_head <= in_data;
          else if (w_push)     r_tail <= in_data;
        end
        FULL:  if (w_pop) r_head <= r_tail;
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_head;
  assign count     = r_state;

endmodule

// File: tb/tb_ysyx_22040000_pipe_buf.sv
// Directed bench for the two-entry pipe buffer: reset, stall, drain, flush,
// mid-operation reset and an ordered streaming run.
module tb_ysyx_22040000_pipe_buf;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  count;

  int errors = 0;
  int checks = 0;

  ysyx_22040000_pipe_buf #(.N(32), .INIT(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int snd;
    int rcv;
    int mdl_cnt;
    int pops;
    int pushes;
    logic do_push;
    logic do_pop;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);

    // Fill while stalled
    in_valid = 1'b1; in_data = 32'hA;
    step();
    check("push1_count", count, 1);
    check("push1_out_valid", out_valid, 1);
    check("push1_out_data", out_data, 32'hA);
    in_data = 32'hB;
    step();
    check("push2_count", count, 2);
    check("push2_in_ready", in_ready, 0);
    check("push2_out_data", out_data, 32'hA);
    in_data = 32'hC;
    step();
    check("full_reject_count", count, 2);
    check("stall_out_data", out_data, 32'hA);

    // Drain from FULL with C offered; C must wait until in_ready returns
    out_ready = 1'b1;
    step();
    check("drain1_out_data", out_data, 32'hB);
    check("drain1_count", count, 1);
    check("drain1_in_ready", in_ready, 1);
    step();
    check("drain2_out_data", out_data, 32'hC);
    check("drain2_count", count, 1);
    in_valid = 1'b0;
    step();
    check("drain3_count", count, 0);
    check("drain3_out_valid", out_valid, 0);

    // Flush from FULL discards the same-cycle push of D
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1;
    step();
    in_data = 32'h2;
    step();
    check("pre_flush_count", count, 2);
    flush = 1'b1; in_data = 32'hD;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", count, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    step();
    check("post_flush_out_valid", out_valid, 0);
    in_valid = 1'b1; in_data = 32'hE;
    step();
    in_valid = 1'b0;
    check("after_flush_out_data", out_data, 32'hE);
    check("after_flush_count", count, 1);

    // Pop coinciding with flush
    out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b0;
    check("flush_pop_count", count, 0);

    // Reset while FULL, with a push offered during reset
    in_valid = 1'b1; in_data = 32'h5;
    step();
    in_data = 32'h6;
    step();
    check("pre_rst_count", count, 2);
    rst = 1'b1; in_data = 32'h7;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("midrst_count", count, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    check("post_rst_out_valid", out_valid, 0);

    // Randomised streaming of 0..99
    snd = 0; rcv = 0; mdl_cnt = 0;
    for (int cyc = 0; cyc < 3000 && rcv < 100; cyc++) begin
      in_valid  = (snd < 100) && ($urandom_range(0, 1) == 1);
      in_data   = snd;
      out_ready = ($urandom_range(0, 2) != 0);
      do_push = in_valid && in_ready;
      do_pop  = out_valid && out_ready;
      if (do_pop) check("stream_order", out_data, rcv);
      step();
      if (do_push) begin snd++; mdl_cnt++; end
      if (do_pop)  begin rcv++; mdl_cnt--; end
      check("stream_count", count, mdl_cnt);
    end
    check("stream_received", rcv, 100);

    // Throughput with both sides held high
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("tp_start_empty", count, 0);
    pops = 0; pushes = 0;
    in_valid = 1'b1;
    for (int k = 0; k < 21; k++) begin
      in_data = 200 + k;
      do_push = in_ready;
      do_pop  = out_valid;
      if (do_pop) check("tp_order", out_data, 200 + pops);
      step();
      if (do_push) pushes++;
      if (do_pop)  pops++;
    end
    check("tp_pushes", pushes, 21);
    check("tp_pops", pops, 20);
    in_valid = 1'b0;
    check("tp_last_out_data", out_data, 220);
    step();
    check("tp_drained", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22040000_pipe_buf.md
YSYX_22040000_PIPE_BUF -- requirements
Module: ysyx_22040000_pipe_buf

Interface
REQ-001 Parameter N, default 32: payload width in bits.
REQ-002 Parameter INIT, default {N{1'b0}}: storage value after reset.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  synchronous discard of all buffered entries.
REQ-006 in_valid  input  1  upstream offers in_data.
REQ-007 in_ready  output  1  buffer accepts in_data this cycle.
REQ-008 in_data  input  N  upstream payload.
REQ-009 out_valid  output  1  out_data holds a buffered entry.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  N  oldest buffered entry.
REQ-012 count  output  2  number of buffered entries, 0..2.

Function
REQ-013 The block SHALL be a 2-entry in-order buffer cutting all valid/ready combinational paths between its two sides.
REQ-014 The state SHALL be one of EMPTY (count=0), ONE (count=1), FULL (count=2), and no other encoding.
REQ-015 in_ready SHALL be driven from a register as (state != FULL), with no combinational dependence on out_ready or in_valid.
REQ-016 out_valid SHALL equal (state != EMPTY), from registers only.
REQ-017 A push SHALL occur when in_valid && in_ready; a pop SHALL occur when out_valid && out_ready.
REQ-018 Transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE; FULL+pop->ONE; otherwise hold.
REQ-019 Push in EMPTY: in_data SHALL appear on out_data with out_valid=1 the next cycle, giving 1-cycle latency.
REQ-020 Simultaneous push and pop in ONE: out_data SHALL become the newly pushed value next cycle, and count SHALL stay 1.
REQ-021 Pop in FULL: the second-oldest entry SHALL move to out_data next cycle.
REQ-022 No push SHALL be accepted in FULL, even with out_ready=1; in_ready rises the cycle after that pop.
REQ-023 While out_valid=1 and out_ready=0, out_data SHALL remain bit-stable.
REQ-024 Entries SHALL leave in exact arrival order with no loss or duplication.
REQ-025 Sustained in_valid=1 and out_ready=1 SHALL give one transfer per cycle on each side in steady state.
REQ-026 flush=1 SHALL force state EMPTY next cycle, and the same-cycle push SHALL be discarded.
REQ-027 A pop coinciding with flush SHALL still count as a completed transfer downstream.
REQ-028 flush SHALL NOT alter stored data values, only validity.
REQ-029 When out_valid=0, out_data SHALL hold its last value, and benches SHALL NOT check it.
REQ-030 count SHALL always equal the number of entries held, and SHALL never wrap.

Reset
REQ-031 rst SHALL take priority over flush, push and pop.
REQ-032 After a clock edge with rst=1: state EMPTY, count=0, out_valid=0, in_ready=1, all storage=INIT, out_data=INIT.
REQ-033 rst asserted mid-operation SHALL drop all entries, and no pushed value SHALL appear after rst deasserts.

Verification
REQ-034 Reset then idle, N=32: count=0, out_valid=0, in_ready=1, out_data=0.
REQ-035 Push 0xA, 0xB with out_ready=0: count 1 then 2, in_ready=0 after the second push, and out_data stays 0xA while stalled.
REQ-036 In FULL (0xA,0xB), out_ready=1 for 2 cycles with in_valid=1, in_data=0xC: output sequence 0xA, 0xB, then 0xC appears in order; 0xC accepted only after in_ready returns to 1.
REQ-037 Streaming 0..99 with random in_valid/out_ready: output exactly 0..99 in order, and throughput is 1/cycle when both are held at 1.
REQ-038 FULL with flush=1 and in_valid=1 (0xD): next cycle count=0, out_valid=0, and 0xD never emitted.
REQ-039 rst pulsed while count=2: next cycle count=0, out_data=INIT, and neither old entry is emitted afterwards.
